// File: rtl/char_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : char_pkg
//  Description : Shared definitions for the character scroller. Holds the
//                default glyph size, the FSM state encoding, the blank-glyph
//                constant and the 6x6 base font used by glyph_rom.
//                The base font is stored row-major with row 0 / column 0 in
//                the MSB, so each literal reads top-left to bottom-right.
//  Revision    : 1.0 - initial release
// ============================================================================
package char_pkg;

   localparam int GLYPH_W_DEF = 6;
   localparam int GLYPH_H_DEF = 6;

   // Native size of the stored font; other window sizes crop or zero-pad it.
   localparam int BASE_DIM  = 6;
   localparam int BASE_BITS = BASE_DIM * BASE_DIM;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_SHIFT = 2'd2,
      ST_GAP   = 2'd3
   } state_t;

   localparam logic [BASE_BITS-1:0] BLANK_GLYPH = '0;

   // Each literal is row0_row1_..._row5; within a row the first bit is the
   // leftmost column.
   function automatic logic [BASE_BITS-1:0] base_glyph(input logic [7:0] code);
      logic [BASE_BITS-1:0] g;
      case (code)
         8'h41: g = 36'b011110_110011_110011_111111_110011_110011; // A
         8'h42: g = 36'b111110_110011_111110_110011_110011_111110; // B
         8'h43: g = 36'b011111_110000_110000_110000_110000_011111; // C
         8'h44: g = 36'b111110_110011_110011_110011_110011_111110; // D
         8'h45: g = 36'b111111_110000_111110_110000_110000_111111; // E
         8'h46: g = 36'b111111_110000_111110_110000_110000_110000; // F
         8'h47: g = 36'b011111_110000_110000_110111_110011_011111; // G
         8'h48: g = 36'b110011_110011_111111_110011_110011_110011; // H
         8'h49: g = 36'b111111_001100_001100_001100_001100_111111; // I
         8'h4A: g = 36'b000011_000011_000011_000011_110011_011110; // J
         8'h4B: g = 36'b110011_110110_111100_111100_110110_110011; // K
         8'h4C: g = 36'b110000_110000_110000_110000_110000_111111; // L
         8'h4D: g = 36'b100001_110011_101101_100001_100001_100001; // M
         8'h4E: g = 36'b100001_110001_101001_100101_100011_100001; // N
         8'h4F: g = 36'b011110_110011_110011_110011_110011_011110; // O
         8'h50: g = 36'b111110_110011_110011_111110_110000_110000; // P
         8'h51: g = 36'b011110_110011_110011_110011_110110_011011; // Q
         8'h52: g = 36'b111110_110011_110011_111110_110110_110011; // R
         8'h53: g = 36'b011111_110000_011110_000011_000011_111110; // S
         8'h54: g = 36'b111111_001100_001100_001100_001100_001100; // T
         8'h55: g = 36'b110011_110011_110011_110011_110011_011110; // U
         8'h56: g = 36'b110011_110011_110011_110011_011110_001100; // V
         8'h57: g = 36'b100001_100001_100001_101101_110011_100001; // W
         8'h58: g = 36'b110011_011110_001100_001100_011110_110011; // X
         8'h59: g = 36'b110011_110011_011110_001100_001100_001100; // Y
         8'h5A: g = 36'b111111_000110_001100_011000_110000_111111; // Z
         8'h30: g = 36'b011110_110011_110111_111011_110011_011110; // 0
         8'h31: g = 36'b001100_011100_001100_001100_001100_011110; // 1
         8'h32: g = 36'b011110_110011_000110_001100_011000_111111; // 2
         8'h33: g = 36'b111110_000011_011110_000011_000011_111110; // 3
         8'h34: g = 36'b000110_001110_010110_111111_000110_000110; // 4
         8'h35: g = 36'b111111_110000_111110_000011_000011_111110; // 5
         8'h36: g = 36'b011110_110000_111110_110011_110011_011110; // 6
         8'h37: g = 36'b111111_000011_000110_001100_011000_011000; // 7
         8'h38: g = 36'b011110_110011_011110_110011_110011_011110; // 8
         8'h39: g = 36'b011110_110011_110011_011111_000011_011110; // 9
         8'h21: g = 36'b001100_001100_001100_001100_000000_001100; // !
         default: g = BLANK_GLYPH;
      endcase
      return g;
   endfunction

endpackage
`default_nettype wire

// File: rtl/glyph_rom.sv
`default_nettype none
// ============================================================================
//  Module      : glyph_rom
//  Description : Character code to glyph bitmap lookup with one cycle of
//                registered latency. Output row r sits at
//                [r*GLYPH_W +: GLYPH_W] with bit GLYPH_W-1 as the leftmost
//                column. Unknown codes give an all-zero glyph.
//  Ports       : clk   - clock
//                rst_n - asynchronous active-low reset
//                code  - 8-bit character code
//                glyph - registered GLYPH_W*GLYPH_H bitmap
//  Revision    : 1.0 - initial release
// ============================================================================
module glyph_rom
   import char_pkg::*;
#(
   parameter int GLYPH_W = GLYPH_W_DEF,
   parameter int GLYPH_H = GLYPH_H_DEF
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [7:0]                 code,
   output logic [GLYPH_W*GLYPH_H-1:0] glyph
);

   logic [BASE_BITS-1:0]       base;
   logic [GLYPH_W*GLYPH_H-1:0] mapped;

   always_comb base = base_glyph(code);

   // Re-pack the fixed 6x6 font into the window geometry: crop when the
   // window is smaller, pad right/bottom with blanks when it is larger.
   for (genvar r = 0; r < GLYPH_H; r++) begin : g_row
      for (genvar c = 0; c < GLYPH_W; c++) begin : g_col
         if (r < BASE_DIM && c < BASE_DIM) begin : g_font
            assign mapped[r*GLYPH_W + GLYPH_W-1-c] = base[BASE_BITS-1 - (r*BASE_DIM + c)];
         end else begin : g_pad
            assign mapped[r*GLYPH_W + GLYPH_W-1-c] = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) glyph <= '0;
      else        glyph <= mapped;
   end

endmodule
`default_nettype wire

// File: rtl/char_scroller.sv
`default_nettype none
// ============================================================================
//  Module      : char_scroller
//  Description : Scrolls characters leftwards through a GLYPH_W x GLYPH_H
//                window, one column per scroll tick, with GAP blank columns
//                after each glyph and a one-entry input holding register.
//  Ports       : clk        - clock
//                rst_n      - asynchronous active-low reset
//                enable     - run the tick divider and scrolling
//                step_div   - tick period minus one, in clk cycles
//                char_in    - ASCII code to display
//                char_valid - char_in valid
//                char_ready - holding register empty
//                frame      - window image, row r at [r*GLYPH_W +: GLYPH_W]
//                frame_upd  - one-cycle pulse when frame changes
//                busy       - FSM not idle
//  Revision    : 1.0 - initial release
// ============================================================================
module char_scroller
   import char_pkg::*;
#(
   parameter int GLYPH_W = GLYPH_W_DEF,
   parameter int GLYPH_H = GLYPH_H_DEF,
   parameter int GAP     = 1,
   parameter int DIV_W   = 16
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       enable,
   input  logic [DIV_W-1:0]           step_div,
   input  logic [7:0]                 char_in,
   input  logic                       char_valid,
   output logic                       char_ready,
   output logic [GLYPH_W*GLYPH_H-1:0] frame,
   output logic                       frame_upd,
   output logic                       busy
);

   localparam int              CW       = $clog2(GLYPH_W);
   localparam logic [CW-1:0]   LAST_COL = CW'(GLYPH_W - 1);
   localparam logic [2:0]      GAP_LAST = (GAP > 0) ? 3'(GAP - 1) : 3'd0;

   state_t                     state;
   logic                       hold_valid;
   logic [7:0]                 hold_char;
   logic [7:0]                 cur_char;
   logic [CW-1:0]              col;
   logic [2:0]                 gap_cnt;
   logic [DIV_W-1:0]           div_cnt;
   logic                       tick_pend;

   logic                       tick;
   logic                       advance;
   logic [GLYPH_W*GLYPH_H-1:0] glyph;
   logic [CW-1:0]              col_rev;
   logic [GLYPH_H-1:0]         glyph_col;
   logic [GLYPH_H-1:0]         ins_col;
   logic [GLYPH_W*GLYPH_H-1:0] shifted;

   assign char_ready = ~hold_valid;
   assign tick       = enable && (div_cnt == step_div);
   // A tick that landed during LOAD is replayed on the first SHIFT cycle.
   assign advance    = tick || (tick_pend && enable);

   // cur_char is stable from LOAD onwards, so the glyph is valid in SHIFT
   // even if a new character is captured into the holding register.
   glyph_rom #(
      .GLYPH_W (GLYPH_W),
      .GLYPH_H (GLYPH_H)
   ) u_glyph_rom (
      .clk   (clk),
      .rst_n (rst_n),
      .code  (cur_char),
      .glyph (glyph)
   );

   assign col_rev = LAST_COL - col;
   assign ins_col = (state == ST_SHIFT) ? glyph_col : '0;

   for (genvar r = 0; r < GLYPH_H; r++) begin : g_line
      logic [GLYPH_W-1:0] row_bits;
      assign row_bits     = glyph[r*GLYPH_W +: GLYPH_W];
      assign glyph_col[r] = row_bits[col_rev];
      // Leftmost column falls off, new column enters on the right.
      assign shifted[r*GLYPH_W +: GLYPH_W] = {frame[r*GLYPH_W +: GLYPH_W-1], ins_col[r]};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         frame      <= '0;
         frame_upd  <= 1'b0;
         busy       <= 1'b0;
         hold_valid <= 1'b0;
         hold_char  <= '0;
         cur_char   <= '0;
         col        <= '0;
         gap_cnt    <= '0;
         div_cnt    <= '0;
         tick_pend  <= 1'b0;
      end else begin
         frame_upd <= 1'b0;

         if (enable) div_cnt <= tick ? '0 : div_cnt + 1'b1;

         // Capture only when empty; a release below only happens when full,
         // so the two never collide.
         if (char_valid && !hold_valid) begin
            hold_valid <= 1'b1;
            hold_char  <= char_in;
         end

         case (state)
            ST_IDLE: begin
               if (tick) begin
                  frame     <= shifted;
                  frame_upd <= 1'b1;
               end
               if (hold_valid) begin
                  state      <= ST_LOAD;
                  busy       <= 1'b1;
                  hold_valid <= 1'b0;
                  cur_char   <= hold_char;
               end
            end

            ST_LOAD: begin
               tick_pend <= tick;
               col       <= '0;
               state     <= ST_SHIFT;
            end

            ST_SHIFT: begin
               if (advance) begin
                  frame     <= shifted;
                  frame_upd <= 1'b1;
                  tick_pend <= 1'b0;
                  if (col == LAST_COL) begin
                     col     <= '0;
                     gap_cnt <= '0;
                     if (GAP > 0) begin
                        state <= ST_GAP;
                     end else if (hold_valid) begin
                        state      <= ST_LOAD;
                        hold_valid <= 1'b0;
                        cur_char   <= hold_char;
                     end else begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                     end
                  end else begin
                     col <= col + 1'b1;
                  end
               end
            end

            ST_GAP: begin
               if (tick) begin
                  frame     <= shifted;
                  frame_upd <= 1'b1;
                  if (gap_cnt == GAP_LAST) begin
                     gap_cnt <= '0;
                     if (hold_valid) begin
                        state      <= ST_LOAD;
                        hold_valid <= 1'b0;
                        cur_char   <= hold_char;
                     end else begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                     end
                  end else begin
                     gap_cnt <= gap_cnt + 1'b1;
                  end
               end
            end

            default: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire
